// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port round-robin arbiter/sequencer for the single-port
//               data memory. Define DMEM_ARB_FIXED_PRIO_EN for fixed priority.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_cmd_we;
    logic [ADDR_W-1:0]   r_cmd_addr;
    logic [DATA_W-1:0]   r_cmd_wdata;
    logic                r_owner;
    logic                r_gnt0;
    logic                r_gnt1;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_win1;
    logic                w_load_cmd;
    logic                w_load_rdata;
    logic                w_gnt0_nxt;
    logic                w_gnt1_nxt;
    logic                w_rvalid0_nxt;
    logic                w_rvalid1_nxt;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_win1 = req1 & ~req0;
`else
    // Reset to 1 so that port 0 takes the first tie.
    logic r_last_owner;

    assign w_win1 = req1 & (~req0 | ~r_last_owner);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= 1'b1;
        end else if (r_state == ST_ACCESS) begin
            r_last_owner <= r_owner;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_cmd    = 1'b0;
        w_load_rdata  = 1'b0;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_rvalid0_nxt = 1'b0;
        w_rvalid1_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req0 | req1) begin
                    w_load_cmd  = 1'b1;
                    w_gnt0_nxt  = ~w_win1;
                    w_gnt1_nxt  = w_win1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!r_cmd_we) begin
                    w_load_rdata  = 1'b1;
                    w_rvalid0_nxt = ~r_owner;
                    w_rvalid1_nxt = r_owner;
                end
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            r_owner     <= 1'b0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_gnt0    <= w_gnt0_nxt;
            r_gnt1    <= w_gnt1_nxt;
            r_rvalid0 <= w_rvalid0_nxt;
            r_rvalid1 <= w_rvalid1_nxt;
            if (w_load_cmd) begin
                r_cmd_we    <= w_win1 ? we1    : we0;
                r_cmd_addr  <= w_win1 ? addr1  : addr0;
                r_cmd_wdata <= w_win1 ? wdata1 : wdata0;
                r_owner     <= w_win1;
            end
            if (w_load_rdata) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    // Enables decode straight from state so an async reset drops them at once.
    assign mem_wr_en = (r_state == ST_ACCESS) &  r_cmd_we;
    assign mem_rd_en = (r_state == ST_ACCESS) & ~r_cmd_we;
    assign mem_addr  = r_cmd_addr;
    assign mem_wdata = r_cmd_wdata;
    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign rvalid0   = r_rvalid0;
    assign rvalid1   = r_rvalid1;
    assign rdata     = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
`default_nettype none

module tb_dmem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic              mem_wr_en, mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    int errors = 0;
    int checks = 0;
    bit fixed_prio;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr_en) mem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_wr_en (mem_wr_en),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later; invariants every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("inv_gnt_both",    64'(gnt0 & gnt1), 64'd0);
        chk("inv_rvalid_both", 64'(rvalid0 & rvalid1), 64'd0);
        chk("inv_en_both",     64'(mem_wr_en & mem_rd_en), 64'd0);
        chk("inv_en_in_access", 64'(mem_wr_en | mem_rd_en), 64'(gnt0 | gnt1));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt0"},    64'(gnt0), 64'd0);
        chk({tag, "_gnt1"},    64'(gnt1), 64'd0);
        chk({tag, "_rvalid0"}, 64'(rvalid0), 64'd0);
        chk({tag, "_rvalid1"}, 64'(rvalid1), 64'd0);
        chk({tag, "_rdata"},   64'(rdata), 64'd0);
        chk({tag, "_wr_en"},   64'(mem_wr_en), 64'd0);
        chk({tag, "_rd_en"},   64'(mem_rd_en), 64'd0);
        chk({tag, "_addr"},    64'(mem_addr), 64'd0);
        chk({tag, "_wdata"},   64'(mem_wdata), 64'd0);
    endtask

    task automatic write1(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d;
        tick();
        chk("w1_gnt1", 64'(gnt1), 64'd1);
        chk("w1_addr", 64'(mem_addr), 64'(a));
        req1 = 1'b0; we1 = 1'b0;
        tick();
        chk("w1_no_rvalid", 64'(rvalid1), 64'd0);
    endtask

    initial begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        fixed_prio = 1'b1;
`else
        fixed_prio = 1'b0;
`endif
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();
        chk("idle_no_gnt", 64'(gnt0 | gnt1), 64'd0);

        // T1: port 0 write
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd5; wdata0 = 32'hDEADBEEF;
        tick();
        chk("t1_gnt0",   64'(gnt0), 64'd1);
        chk("t1_gnt1",   64'(gnt1), 64'd0);
        chk("t1_wr_en",  64'(mem_wr_en), 64'd1);
        chk("t1_addr",   64'(mem_addr), 64'd5);
        chk("t1_wdata",  64'(mem_wdata), 64'hDEADBEEF);
        req0 = 1'b0; we0 = 1'b0;
        tick();
        chk("t1_gnt0_pulse", 64'(gnt0), 64'd0);
        chk("t1_wr_en_off",  64'(mem_wr_en), 64'd0);
        chk("t1_no_rvalid",  64'(rvalid0 | rvalid1), 64'd0);
        chk("t1_mem5",       64'(mem[5]), 64'hDEADBEEF);

        // T2: port 1 read of the word just written
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd5;
        tick();
        chk("t2_gnt1",  64'(gnt1), 64'd1);
        chk("t2_rd_en", 64'(mem_rd_en), 64'd1);
        chk("t2_addr",  64'(mem_addr), 64'd5);
        req1 = 1'b0;
        tick();
        chk("t2_rvalid1", 64'(rvalid1), 64'd1);
        chk("t2_rvalid0", 64'(rvalid0), 64'd0);
        chk("t2_rdata",   64'(rdata), 64'hDEADBEEF);
        chk("t2_gnt1_off", 64'(gnt1), 64'd0);
        tick();
        chk("t2_rvalid1_pulse", 64'(rvalid1), 64'd0);
        chk("t2_rdata_hold",    64'(rdata), 64'hDEADBEEF);

        // Preload through port 1 for T3/T4
        write1(6'd1, 32'hA1A10001);
        write1(6'd2, 32'hB2B20002);
        write1(6'd7, 32'h0BAD0007);

        // T3: both ports read continuously after reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
        for (int i = 0; i < 8; i++) begin
            bit g_cyc, p1;
            tick();
            g_cyc = (i % 2) == 0;
            p1    = !fixed_prio && ((i % 4) >= 2);
            chk($sformatf("t3_gnt0_%0d", i),    64'(gnt0),    64'(g_cyc && !p1));
            chk($sformatf("t3_gnt1_%0d", i),    64'(gnt1),    64'(g_cyc && p1));
            chk($sformatf("t3_rvalid0_%0d", i), 64'(rvalid0), 64'(!g_cyc && !p1));
            chk($sformatf("t3_rvalid1_%0d", i), 64'(rvalid1), 64'(!g_cyc && p1));
            if (!g_cyc)
                chk($sformatf("t3_rdata_%0d", i), 64'(rdata),
                    p1 ? 64'hB2B20002 : 64'hA1A10001);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        // T4: reset during a port 0 write, before the memory negedge
        req0 = 1'b1; we0 = 1'b1; addr0 = 6'd7; wdata0 = 32'h77777777;
        tick();
        chk("t4_wr_en", 64'(mem_wr_en), 64'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t4_rst");
        req0 = 1'b0; we0 = 1'b0;
        @(negedge clk);
        #1;
        chk("t4_mem7_kept", 64'(mem[7]), 64'h0BAD0007);
        tick();
        tick();
        chk("t4_no_rvalid", 64'(rvalid0 | rvalid1), 64'd0);
        rst_n = 1'b1;
        tick();

`ifdef DMEM_ARB_FIXED_PRIO_EN
        // T6: port 1 starves under fixed priority
        begin
            int n_gnt0 = 0;
            req0 = 1'b1; we0 = 1'b0; addr0 = 6'd1;
            req1 = 1'b1; we1 = 1'b0; addr1 = 6'd2;
            for (int i = 0; i < 10; i++) begin
                tick();
                chk($sformatf("t6_gnt1_%0d", i), 64'(gnt1), 64'd0);
                if (gnt0) n_gnt0++;
            end
            chk("t6_gnt0_count", 64'(n_gnt0), 64'd5);
            req0 = 1'b0; req1 = 1'b0;
            tick();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
